uart_rx_seq: RTL and testbench

Receive sequencer for the UART receive path: it qualifies the start bit, times mid-bit sampling from a 16x oversample tick, steers the bit-shift and load strobes, checks parity and stop, and hands the completed character to the host side through a valid/ready handshake. It sits between the baud generator and the host interface and replaces the free-running baud-clocked receive control with a single-clock, tick-enabled controller. It also reports framing, parity and overrun errors.

---
 rtl/uart_rx_seq.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_seq.sv
// uart_rx_seq: tick-enabled UART receive sequencer.
// Qualifies the start bit, samples mid-bit from a 16x (OS_RATE) oversample tick,
// shifts data LSB first, checks parity and stop, and holds the character for the
// host behind a valid/ready handshake with sticky overrun reporting.
module uart_rx_seq #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    input  logic                 ovr_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 shift_strobe
);

    localparam int OSW = $clog2(OS_RATE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    // os_cnt counts ticks since the last sample point; the terminal values are
    // one below the period because the compare happens before the increment.
    localparam logic [OSW-1:0] OS_HALF_M1 = OSW'(OS_RATE / 2 - 1);
    localparam logic [OSW-1:0] OS_FULL_M1 = OSW'(OS_RATE - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 par_bad_q, par_bad_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 frame_done;
    logic                 stop_low;
    logic                 strobe;
    logic                 load;

    // Frame sequencing: everything except the handshake advances only on ticks.
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_bad_d  = par_bad_q;
        frame_done = 1'b0;
        stop_low   = 1'b0;
        strobe     = 1'b0;
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd) begin
                        state_d   = S_START;
                        os_cnt_d  = '0;
                        par_en_d  = parity_en;
                        par_odd_d = parity_odd;
                        par_bad_d = 1'b0;
                    end
                end
                S_START: begin
                    if (os_cnt_q == OS_HALF_M1) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rxd ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_FULL_M1) begin
                        os_cnt_d  = '0;
                        shift_d   = {rxd, shift_q[DATA_BITS-1:1]};
                        strobe    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST)
                            state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (os_cnt_q == OS_FULL_M1) begin
                        os_cnt_d  = '0;
                        par_bad_d = ((^shift_q) ^ rxd) != par_odd_q;
                        state_d   = S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (os_cnt_q == OS_FULL_M1) begin
                        os_cnt_d   = '0;
                        frame_done = 1'b1;
                        stop_low   = ~rxd;
                        state_d    = rxd ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A completed frame loads if the holding slot is free or being freed now.
    assign load = frame_done & (~rx_valid_q | rx_ready);

    // Host-side holding register, handshake and sticky overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (load) begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            parity_err_d = par_bad_q & par_en_q;
            frame_err_d  = stop_low;
        end
        if (ovr_clr) overrun_d = 1'b0;
        if (frame_done && !load) overrun_d = 1'b1;
    end

    // State registers; reset abandons any partial frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != S_IDLE);
    assign shift_strobe = strobe;

endmodule

// File: tb/tb_uart_rx_seq.sv
// Self-checking bench for uart_rx_seq: table vectors, directed corner cases and
// randomized frames against a character-level reference model.
module tb_uart_rx_seq;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          sys_clk, rst_n, baud_tick, rxd, parity_en, parity_odd;
    logic          rx_ready, ovr_clr;
    logic [DB-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, overrun, busy, shift_strobe;

    int checks = 0;
    int errors = 0;
    int scnt   = 0;
    int stray  = 0;

    // Character-level model of what the host side should be holding.
    logic          m_valid, m_perr, m_ferr, m_ovr;
    logic [DB-1:0] m_data;

    uart_rx_seq #(.DATA_BITS(DB), .OS_RATE(OS)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .baud_tick(baud_tick), .rxd(rxd),
        .parity_en(parity_en), .parity_odd(parity_odd), .rx_ready(rx_ready),
        .ovr_clr(ovr_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .busy(busy), .shift_strobe(shift_strobe)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count data-sample strobes mid-cycle; a strobe without a tick is wrong.
    always @(negedge sys_clk) begin
        if (shift_strobe) begin
            scnt++;
            if (!baud_tick) stray++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One tick cycle followed by one idle cycle.
    task automatic tick(input logic b, input logic rdy);
        rxd = b; rx_ready = rdy; baud_tick = 1'b1;
        @(posedge sys_clk); #1;
        baud_tick = 1'b0; rx_ready = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge sys_clk); #1;
        rx_ready = 1'b0;
        m_valid = 1'b0;
        chk("accept_clears_valid", rx_valid, 0);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        @(posedge sys_clk); #1;
        ovr_clr = 1'b0;
        m_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);
    endtask

    // Drive a whole frame, each bit held OS ticks; abort_at stops early.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic pb, input logic sb, input logic rdy_stop,
                              input int abort_at);
        int   nb, stop_idx, bp;
        logic lvl;
        parity_en = pe; parity_odd = po; scnt = 0;
        nb       = DB + 2 + int'(pe);
        stop_idx = OS * (DB + 1 + int'(pe)) + OS / 2;
        for (int i = 0; i < nb * OS; i++) begin
            if (i == abort_at) return;
            bp = i / OS;
            if (bp == 0)                     lvl = 1'b0;
            else if (bp <= DB)               lvl = d[bp-1];
            else if (pe && bp == DB + 1)     lvl = pb;
            else                             lvl = sb;
            tick(lvl, rdy_stop && (i == stop_idx));
            // Parity config must be latched at the start tick, not followed.
            if (i == 0) begin
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
            end
            if (i == stop_idx - 1) begin
                chk("valid_before_stop", rx_valid, m_valid);
                chk("busy_in_frame", busy, 1);
            end
            if (i == stop_idx) chk("busy_after_stop", busy, !sb);
        end
    endtask

    task automatic apply_frame(input logic [7:0] d, input logic pe, input logic po,
                               input logic pb, input logic sb, input logic rdy);
        logic ep;
        send_frame(d, pe, po, pb, sb, rdy, -1);
        ep = pe && ((($countones(d) + int'(pb)) % 2) != int'(po));
        if (!m_valid || rdy) begin
            m_valid = 1'b1; m_data = d; m_perr = ep; m_ferr = !sb;
        end else begin
            m_ovr = 1'b1;
        end
        chk("rx_valid", rx_valid, m_valid);
        chk("rx_data", rx_data, m_data);
        chk("parity_err", parity_err, m_perr);
        chk("frame_err", frame_err, m_ferr);
        chk("overrun", overrun, m_ovr);
        chk("strobe_count", scnt, DB);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe, po, pb;
        logic [7:0] exp_d;
        logic       exp_perr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{8'h37, 1'b1, 1'b0, 1'b1, 8'h37, 1'b0};
        tbl[2] = '{8'h37, 1'b1, 1'b0, 1'b0, 8'h37, 1'b1};
        tbl[3] = '{8'h37, 1'b1, 1'b1, 1'b0, 8'h37, 1'b0};
        tbl[4] = '{8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b1};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};

        rst_n = 1'b0; baud_tick = 1'b0; rxd = 1'b1; parity_en = 1'b0;
        parity_odd = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
        m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outputs", {rx_valid, rx_data, parity_err, frame_err, overrun, busy, shift_strobe}, 0);
        rst_n = 1'b1;
        repeat (2) tick(1'b1, 1'b0);

        // Table vectors: 8N1 / 8E1 / 8O1 characters, accepted after each.
        for (int v = 0; v < 7; v++) begin
            apply_frame(tbl[v].d, tbl[v].pe, tbl[v].po, tbl[v].pb, 1'b1, 1'b0);
            chk("tbl_data", rx_data, tbl[v].exp_d);
            chk("tbl_perr", parity_err, tbl[v].exp_perr);
            chk("tbl_ferr", frame_err, 0);
            accept();
            repeat (2) tick(1'b1, 1'b0);
        end

        // False start: low for 3 ticks, aborted at the half-bit check.
        scnt = 0;
        repeat (3) tick(1'b0, 1'b0);
        chk("fs_busy_start", busy, 1);
        repeat (5) tick(1'b1, 1'b0);
        chk("fs_busy_before", busy, 1);
        tick(1'b1, 1'b0);
        chk("fs_busy_after", busy, 0);
        chk("fs_no_valid", rx_valid, 0);
        chk("fs_no_flags", {parity_err, frame_err, overrun}, 0);
        chk("fs_no_strobe", scnt, 0);

        // Break: stop bit low and line held low; exactly one character.
        apply_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("brk_ferr", frame_err, 1);
        chk("brk_wait_high", busy, 1);
        repeat (20) tick(1'b0, 1'b0);
        accept();
        repeat (20) tick(1'b0, 1'b0);
        chk("brk_single_char", rx_valid, 0);
        chk("brk_still_busy", busy, 1);
        tick(1'b1, 1'b0);
        chk("brk_idle", busy, 0);
        repeat (2) tick(1'b1, 1'b0);
        apply_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("brk_next_data", rx_data, 8'h11);
        chk("brk_next_ferr", frame_err, 0);
        accept();

        // Overrun: second frame dropped while the first is still held.
        apply_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0);
        apply_frame(8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_data_kept", rx_data, 8'h01);
        chk("ovr_set", overrun, 1);

        // Asynchronous reset in the middle of data bit 4.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OS * 5 + 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {rx_valid, rx_data, parity_err, frame_err, overrun, busy, shift_strobe}, 0);
        m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (2) tick(1'b1, 1'b0);
        apply_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_next_data", rx_data, 8'h5A);
        accept();

        // Same-cycle accept and load: no overrun, new data held.
        apply_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0);
        apply_frame(8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("same_cycle_data", rx_data, 8'h02);
        chk("same_cycle_valid", rx_valid, 1);
        chk("same_cycle_ovr", overrun, 0);
        accept();

        // Randomized frames against the model.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic pe, po, pb, sb, rdy;
            d   = 8'($urandom);
            pe  = 1'($urandom);
            po  = 1'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            apply_frame(d, pe, po, pb, sb, rdy);
            repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) accept();
            if ($urandom_range(0, 2) == 0) clear_ovr();
        end

        chk("no_stray_strobe", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
